// File: rtl/synth_audio_pkg.sv
// Shared types and constants for the audio attenuator slice.
// Holds the default sample width, the shift width and the FSM state enum.
package synth_audio_pkg;

  localparam int DEFAULT_SAMPLE_W = 16;
  localparam int SHIFT_W          = 4;

  typedef enum logic {
    STEADY,
    PENDING
  } atten_state_t;

endpackage

// File: rtl/zero_cross_detector.sv
// Flags a zero crossing on accepted samples: the sample is zero, or its
// sign differs from the previous accepted one. Ports: clock, reset, accept,
// sample in; crossing out (qualified by accept). Previous sign resets to 0.
module zero_cross_detector
  import synth_audio_pkg::*;
#(
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                crossing
);

  logic prev_neg;
  logic cur_neg;
  logic is_zero;

  assign cur_neg  = sample[SAMPLE_W-1];
  assign is_zero  = (sample == '0);
  assign crossing = accept && (is_zero || (cur_neg != prev_neg));

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_neg <= 1'b0;
    end else if (accept) begin
      prev_neg <= cur_neg;
    end
  end

endmodule

// File: rtl/envelope_attenuator.sv
// Streaming attenuator: out = in >>> shift, shift changes deferred to a zero
// crossing or ZC_TIMEOUT accepted samples. Ports: clock, reset (sync, high),
// shift_amount, in_valid/in_ready/in_sample, out_valid/out_ready/out_sample,
// active_shift, shift_pending. Macro ENV_ATTEN_MUTE_EN: shift 15 gives 0.
module envelope_attenuator
  import synth_audio_pkg::*;
#(
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int ZC_TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SHIFT_W-1:0]         shift_amount,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       out_ready,
  output logic [SHIFT_W-1:0]         active_shift,
  output logic                       shift_pending
);

  localparam int CNT_W =
    (ZC_TIMEOUT > 2) ? $clog2(ZC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ZC_TIMEOUT - 1);

  atten_state_t               state;
  logic [CNT_W-1:0]           zc_cnt;
  logic                       accept;
  logic                       crossing;
  logic                       differs;
  logic                       commit;
  logic [SHIFT_W-1:0]         shift_used;
  logic signed [SAMPLE_W-1:0] shifted;

  assign in_ready      = !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign differs       = (shift_amount != active_shift);
  assign shift_pending = (state == PENDING);

  // The committing sample already uses the new shift.
  assign commit = (state == PENDING) && accept &&
                  (crossing || (zc_cnt == CNT_LAST));
  assign shift_used = commit ? shift_amount : active_shift;

  always_comb begin
    shifted = in_sample >>> shift_used;
`ifdef ENV_ATTEN_MUTE_EN
    // Full mute: avoid the -1 residue of negative samples.
    if (&shift_used) begin
      shifted = '0;
    end
`endif
  end

  zero_cross_detector #(
    .SAMPLE_W (SAMPLE_W)
  ) u_zcd (
    .clock    (clock),
    .reset    (reset),
    .accept   (accept),
    .sample   (in_sample),
    .crossing (crossing)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= STEADY;
      active_shift <= '0;
      zc_cnt       <= '0;
    end else begin
      unique case (state)
        STEADY: begin
          if (differs) begin
            state  <= PENDING;
            zc_cnt <= '0;
          end
        end
        PENDING: begin
          if (commit) begin
            active_shift <= shift_amount;
            state        <= STEADY;
          end else if (!differs) begin
            state <= STEADY;
          end else if (accept) begin
            zc_cnt <= zc_cnt + 1'b1;
          end
        end
        default: state <= STEADY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_sample <= shifted;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_envelope_attenuator.sv
// Directed bench for envelope_attenuator with hand-computed expectations.
// Covers reset, deferred shift, timeout, backpressure, mute and reset stall.
module tb_envelope_attenuator;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        shift_amount;
  logic              in_valid;
  logic signed [15:0] in_sample;
  logic              in_ready;
  logic              out_valid;
  logic signed [15:0] out_sample;
  logic              out_ready;
  logic [3:0]        active_shift;
  logic              shift_pending;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  envelope_attenuator #(
    .SAMPLE_W   (16),
    .ZC_TIMEOUT (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .shift_amount  (shift_amount),
    .in_valid      (in_valid),
    .in_sample     (in_sample),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_sample    (out_sample),
    .out_ready     (out_ready),
    .active_shift  (active_shift),
    .shift_pending (shift_pending)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic signed [15:0] s,
                      input int exp_out, input int exp_sh,
                      input int exp_pend);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check({tag, ".out"}, out_sample, exp_out);
    check({tag, ".shift"}, active_shift, exp_sh);
    check({tag, ".pend"}, shift_pending, exp_pend);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  int mute_exp;

  initial begin
`ifdef ENV_ATTEN_MUTE_EN
    mute_exp = 0;
`else
    mute_exp = -1;
`endif
    reset        = 1'b1;
    shift_amount = 4'd0;
    in_valid     = 1'b0;
    in_sample    = '0;
    out_ready    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.out", out_sample, 0);
    check("rst.shift", active_shift, 0);
    check("rst.pend", shift_pending, 0);
    check("rst.ready", in_ready, 1);
    reset = 1'b0;

    // constant stream, deferred shift 2 until a zero sample
    push("c0", 16'sh4000, 16384, 0, 0);
    push("c1", 16'sh4000, 16384, 0, 0);
    shift_amount = 4'd2;
    idle();
    check("c.pend", shift_pending, 1);
    for (int i = 0; i < 3; i++)
      push("cp", 16'sh4000, 16384, 0, 1);
    push("cz", 16'sh0000, 0, 2, 0);
    push("c2", 16'sh4000, 4096, 2, 0);

    // alternating signs
    shift_amount = 4'd0;
    idle();
    push("a0", 16'sd1000, 250, 2, 1);
    push("a1", -16'sd1000, -1000, 0, 0);
    push("a2", 16'sd1000, 1000, 0, 0);
    shift_amount = 4'd3;
    idle();
    check("a.pend", shift_pending, 1);
    push("a3", -16'sd1000, -125, 3, 0);
    push("a4", 16'sd1000, 125, 3, 0);

    // request returns to active shift: no update
    shift_amount = 4'd5;
    idle();
    push("r0", 16'sd500, 62, 3, 1);
    shift_amount = 4'd3;
    idle();
    check("r.pend", shift_pending, 0);
    check("r.shift", active_shift, 3);

    // timeout on an all-positive stream
    reset = 1'b1;
    shift_amount = 4'd0;
    idle();
    reset = 1'b0;
    push("t0", 16'sd100, 100, 0, 0);
    shift_amount = 4'd5;
    idle();
    for (int k = 1; k <= 64; k++) begin
      if (k < 64)
        push("tw", 16'sh4000, 16384, 0, 1);
      else
        push("tf", 16'sh4000, 512, 5, 0);
    end

    // backpressure
    idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'sh1000;
    @(posedge clock);
    #1;
    check("bp.valid", out_valid, 1);
    check("bp.out", out_sample, 128);
    in_sample = 16'sh2000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("bp.ready", in_ready, 0);
      check("bp.hold", out_sample, 128);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rel", in_ready, 1);
    @(posedge clock);
    #1;
    check("bp.next", out_sample, 256);
    check("bp.v1", out_valid, 1);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("bp.v0", out_valid, 0);

    // shift 15
    shift_amount = 4'd15;
    idle();
    push("m0", 16'sh0000, 0, 15, 0);
    push("m1", 16'sh8000, mute_exp, 15, 0);
    push("m2", 16'sh7FFF, 0, 15, 0);

    // reset while pending with a stalled output
    shift_amount = 4'd0;
    idle();
    check("x.pend", shift_pending, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'sh1234;
    @(posedge clock);
    #1;
    check("x.valid", out_valid, 1);
    check("x.ready", in_ready, 0);
    @(posedge clock);
    #1;
    check("x.stall", active_shift, 15);
    check("x.pend2", shift_pending, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("xr.valid", out_valid, 0);
    check("xr.shift", active_shift, 0);
    check("xr.pend", shift_pending, 0);
    check("xr.ready", in_ready, 1);
    check("xr.out", out_sample, 0);
    reset    = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/envelope_attenuator.md
ENVELOPE_ATTENUATOR -- requirements
Module: envelope_attenuator

Interface
REQ-001 Parameter SAMPLE_W, default 16: signed audio sample width.
REQ-002 Parameter ZC_TIMEOUT, default 64: accepted samples to wait for a zero crossing before forcing a shift update.
REQ-003 clock  input  1: sole clock; all state updates on posedge.
REQ-004 reset  input  1: reset, synchronous, active-high.
REQ-005 shift_amount  input  4: requested attenuation; the sample is right-shifted by this amount.
REQ-006 in_valid  input  1: in_sample valid this cycle.
REQ-007 in_sample  input  SAMPLE_W: signed two's-complement input sample.
REQ-008 in_ready  output  1: block accepts in_sample this cycle.
REQ-009 out_valid  output  1: out_sample valid.
REQ-010 out_sample  output  SAMPLE_W: signed attenuated sample.
REQ-011 out_ready  input  1: consumer accepts out_sample.
REQ-012 active_shift  output  4: shift currently applied to samples.
REQ-013 shift_pending  output  1: requested shift differs from active_shift and is awaiting a zero crossing.

Function
REQ-014 Input accepted when in_valid && in_ready; output handed off when out_valid && out_ready.
REQ-015 in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
REQ-016 Latency: an accepted sample appears on out_sample the next cycle, with out_valid=1.
REQ-017 out_sample = in_sample >>> shift_used, arithmetic shift, sign preserved, SAMPLE_W bits wide.
REQ-018 Output is held stable while out_valid && !out_ready.
REQ-019 FSM states: STEADY and PENDING.
REQ-020 STEADY -> PENDING when shift_amount != active_shift; the timeout counter is cleared on this entry.
REQ-021 In PENDING, each accepted sample is tested for a zero crossing.
  - A zero crossing is in_sample == 0, or a sign differing from the previous accepted sample.
REQ-022 On a zero-crossing sample:
  - active_shift <= shift_amount in the same cycle.
  - That sample already uses the new shift.
  - State returns to STEADY.
REQ-023 In PENDING without a zero crossing, the counter increments per accepted sample.
REQ-024 When the counter reaches ZC_TIMEOUT-1 on an accepted sample, the update is applied as in REQ-022.
REQ-025 If shift_amount changes while PENDING, the target tracks the latest value and the counter is not cleared.
  - If shift_amount returns to active_shift, the FSM goes to STEADY with no update.
REQ-026 shift_amount is sampled only at accepted samples for the update decision; no update occurs during stalls.
REQ-027 shift_pending = (state == PENDING).
REQ-028 The previous-sample sign register updates on every accepted sample.
  - After reset it reads as non-negative.

Reset
REQ-029 Reset applies the following, regardless of in-flight data:
  - out_valid = 0, out_sample = 0.
  - active_shift = 0, state = STEADY.
  - Timeout counter = 0, previous sign = 0.
REQ-030 Reset mid-stall drops the held output; in_ready = 1 on the first cycle after reset.

Configuration
REQ-031 Macro ENV_ATTEN_MUTE_EN, when defined: a sample with shift_used == 4'd15 outputs exactly 0, so negative samples do not leave a -1 residue.
REQ-032 Macro ENV_ATTEN_MUTE_EN, when undefined: shift 15 follows REQ-017 unmodified.

Structure
REQ-033 Shared package synth_audio_pkg holds:
  - SAMPLE_W default.
  - SHIFT_W = 4.
  - The STEADY/PENDING state enum.
REQ-034 Sub-module zero_cross_detector:
  - Holds the previous sign register.
  - Outputs the crossing flag, qualified by accept.

Verification
REQ-035 Stream constant 16'sh4000 with shift 0, then set shift 2 at a positive-only stretch:
  - Outputs stay 16'sh4000 and shift_pending = 1.
  - On the first sample 16'sh0000, output = 0 and active_shift = 2.
REQ-036 Alternate samples +1000/-1000 with a shift change 0 -> 3:
  - The update applies on the next accepted sample.
  - Output -1000 >>> 3 = -125.
REQ-037 ZC_TIMEOUT = 64, all-positive stream, shift 0 -> 5:
  - The 64th accepted sample after the change uses shift 5.
  - No earlier sample uses shift 5.
REQ-038 Backpressure, out_ready = 0 for 5 cycles with in_valid = 1:
  - in_ready = 0 and out_sample is held.
  - No sample is lost or duplicated when out_ready = 1.
REQ-039 Input 16'sh8000 with shift 15:
  - Output 0 with ENV_ATTEN_MUTE_EN defined.
  - Output 16'shFFFF without it.
REQ-040 Assert reset while PENDING with a stalled output:
  - Next cycle out_valid = 0, active_shift = 0, shift_pending = 0.
